// File: rtl/chi_pkg.sv
// rtl/chi_pkg.sv - shared constants and lane type for the Keccak chi step
package chi_pkg;

  localparam int LANE_W    = 64;
  localparam int NUM_LANES = 25;
  localparam int ROW_W     = 5;

  typedef logic [LANE_W-1:0] lane_t;

endpackage

// File: rtl/chi_row.sv
// rtl/chi_row.sv - combinational chi over one five-lane row
module chi_row
  import chi_pkg::*;
#(
  parameter int LANE_W = chi_pkg::LANE_W
) (
  input  logic [ROW_W-1:0][LANE_W-1:0] row_in,
  output logic [ROW_W-1:0][LANE_W-1:0] row_out
);

  // Each lane mixes with its two right-hand neighbours, wrapping inside the row.
  always_comb begin
    row_out = '0;
    for (int x = 0; x < ROW_W; x++) begin
      row_out[x] = row_in[x] ^ (~row_in[(x + 1) % ROW_W] & row_in[(x + 2) % ROW_W]);
    end
  end

endmodule

// File: rtl/chi.sv
// rtl/chi.sv - registered Keccak-f[1600] chi step, one result per cycle
module chi
  import chi_pkg::*;
#(
  parameter int LANE_W    = chi_pkg::LANE_W,
  parameter int NUM_LANES = chi_pkg::NUM_LANES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [LANE_W-1:0] in_data_0,
  input  logic [LANE_W-1:0] in_data_1,
  input  logic [LANE_W-1:0] in_data_2,
  input  logic [LANE_W-1:0] in_data_3,
  input  logic [LANE_W-1:0] in_data_4,
  input  logic [LANE_W-1:0] in_data_5,
  input  logic [LANE_W-1:0] in_data_6,
  input  logic [LANE_W-1:0] in_data_7,
  input  logic [LANE_W-1:0] in_data_8,
  input  logic [LANE_W-1:0] in_data_9,
  input  logic [LANE_W-1:0] in_data_10,
  input  logic [LANE_W-1:0] in_data_11,
  input  logic [LANE_W-1:0] in_data_12,
  input  logic [LANE_W-1:0] in_data_13,
  input  logic [LANE_W-1:0] in_data_14,
  input  logic [LANE_W-1:0] in_data_15,
  input  logic [LANE_W-1:0] in_data_16,
  input  logic [LANE_W-1:0] in_data_17,
  input  logic [LANE_W-1:0] in_data_18,
  input  logic [LANE_W-1:0] in_data_19,
  input  logic [LANE_W-1:0] in_data_20,
  input  logic [LANE_W-1:0] in_data_21,
  input  logic [LANE_W-1:0] in_data_22,
  input  logic [LANE_W-1:0] in_data_23,
  input  logic [LANE_W-1:0] in_data_24,
  output logic              out_valid,
  output logic [LANE_W-1:0] out_data_0,
  output logic [LANE_W-1:0] out_data_1,
  output logic [LANE_W-1:0] out_data_2,
  output logic [LANE_W-1:0] out_data_3,
  output logic [LANE_W-1:0] out_data_4,
  output logic [LANE_W-1:0] out_data_5,
  output logic [LANE_W-1:0] out_data_6,
  output logic [LANE_W-1:0] out_data_7,
  output logic [LANE_W-1:0] out_data_8,
  output logic [LANE_W-1:0] out_data_9,
  output logic [LANE_W-1:0] out_data_10,
  output logic [LANE_W-1:0] out_data_11,
  output logic [LANE_W-1:0] out_data_12,
  output logic [LANE_W-1:0] out_data_13,
  output logic [LANE_W-1:0] out_data_14,
  output logic [LANE_W-1:0] out_data_15,
  output logic [LANE_W-1:0] out_data_16,
  output logic [LANE_W-1:0] out_data_17,
  output logic [LANE_W-1:0] out_data_18,
  output logic [LANE_W-1:0] out_data_19,
  output logic [LANE_W-1:0] out_data_20,
  output logic [LANE_W-1:0] out_data_21,
  output logic [LANE_W-1:0] out_data_22,
  output logic [LANE_W-1:0] out_data_23,
  output logic [LANE_W-1:0] out_data_24
);

  logic [NUM_LANES-1:0][LANE_W-1:0] state_in;
  logic [NUM_LANES-1:0][LANE_W-1:0] state_chi;
  logic [NUM_LANES-1:0][LANE_W-1:0] state_q;

  assign state_in = {in_data_24, in_data_23, in_data_22, in_data_21, in_data_20,
                     in_data_19, in_data_18, in_data_17, in_data_16, in_data_15,
                     in_data_14, in_data_13, in_data_12, in_data_11, in_data_10,
                     in_data_9,  in_data_8,  in_data_7,  in_data_6,  in_data_5,
                     in_data_4,  in_data_3,  in_data_2,  in_data_1,  in_data_0};

  // Rows are independent, so each gets its own combinational slice.
  for (genvar y = 0; y < ROW_W; y++) begin : g_row
    chi_row #(.LANE_W(LANE_W)) u_row (
      .row_in  (state_in[ROW_W*y +: ROW_W]),
      .row_out (state_chi[ROW_W*y +: ROW_W])
    );
  end

  // Capture a new result only when qualified; otherwise hold the last one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        state_q <= state_chi;
      end
    end
  end

  assign {out_data_24, out_data_23, out_data_22, out_data_21, out_data_20,
          out_data_19, out_data_18, out_data_17, out_data_16, out_data_15,
          out_data_14, out_data_13, out_data_12, out_data_11, out_data_10,
          out_data_9,  out_data_8,  out_data_7,  out_data_6,  out_data_5,
          out_data_4,  out_data_3,  out_data_2,  out_data_1,  out_data_0} = state_q;

endmodule

// File: tb/tb_chi.sv
// tb/tb_chi.sv - directed and random checks of the registered chi step
module tb_chi;
  import chi_pkg::*;

  typedef logic [NUM_LANES-1:0][LANE_W-1:0] state_t;

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  logic   in_valid = 1'b0;
  state_t din = '0;
  state_t dout;
  logic   out_valid;

  int total = 0;
  int bad = 0;

  localparam lane_t ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  always #5 clk = ~clk;

  chi dut (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .in_data_0(din[0]),   .in_data_1(din[1]),   .in_data_2(din[2]),   .in_data_3(din[3]),
    .in_data_4(din[4]),   .in_data_5(din[5]),   .in_data_6(din[6]),   .in_data_7(din[7]),
    .in_data_8(din[8]),   .in_data_9(din[9]),   .in_data_10(din[10]), .in_data_11(din[11]),
    .in_data_12(din[12]), .in_data_13(din[13]), .in_data_14(din[14]), .in_data_15(din[15]),
    .in_data_16(din[16]), .in_data_17(din[17]), .in_data_18(din[18]), .in_data_19(din[19]),
    .in_data_20(din[20]), .in_data_21(din[21]), .in_data_22(din[22]), .in_data_23(din[23]),
    .in_data_24(din[24]),
    .out_valid(out_valid),
    .out_data_0(dout[0]),   .out_data_1(dout[1]),   .out_data_2(dout[2]),   .out_data_3(dout[3]),
    .out_data_4(dout[4]),   .out_data_5(dout[5]),   .out_data_6(dout[6]),   .out_data_7(dout[7]),
    .out_data_8(dout[8]),   .out_data_9(dout[9]),   .out_data_10(dout[10]), .out_data_11(dout[11]),
    .out_data_12(dout[12]), .out_data_13(dout[13]), .out_data_14(dout[14]), .out_data_15(dout[15]),
    .out_data_16(dout[16]), .out_data_17(dout[17]), .out_data_18(dout[18]), .out_data_19(dout[19]),
    .out_data_20(dout[20]), .out_data_21(dout[21]), .out_data_22(dout[22]), .out_data_23(dout[23]),
    .out_data_24(dout[24])
  );

  function automatic state_t chi_model(input state_t a);
    state_t r;
    for (int y = 0; y < 5; y++) begin
      for (int x = 0; x < 5; x++) begin
        r[x + 5*y] = a[x + 5*y] ^ (~a[(x + 1) % 5 + 5*y] & a[(x + 2) % 5 + 5*y]);
      end
    end
    return r;
  endfunction

  task automatic check(input string tag, input state_t exp_data, input logic exp_valid);
    total++;
    assert (out_valid === exp_valid) else begin
      bad++;
      $error("FAIL %s out_valid observed=%b expected=%b", tag, out_valid, exp_valid);
    end
    for (int i = 0; i < NUM_LANES; i++) begin
      total++;
      assert (dout[i] === exp_data[i]) else begin
        bad++;
        $error("FAIL %s lane %0d observed=%h expected=%h", tag, i, dout[i], exp_data[i]);
      end
    end
  endtask

  task automatic step(input state_t vec, input logic vld);
    @(negedge clk);
    din = vec;
    in_valid = vld;
    @(posedge clk);
    #1;
  endtask

  initial begin
    state_t v_zero;
    state_t v_ones;
    state_t v_wrap;
    state_t e_wrap;
    state_t v_row;
    state_t e_row;
    state_t v_rand;

    v_zero = '0;
    v_ones = '1;
    v_wrap = '0; v_wrap[1] = ONES;
    e_wrap = '0; e_wrap[1] = ONES; e_wrap[4] = ONES;
    v_row  = '0; v_row[7] = 64'h1;
    e_row  = '0; e_row[5] = 64'h1; e_row[7] = 64'h1;

    // held in reset across edges with valid input
    din = v_ones;
    in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", v_zero, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("idle_after_reset", v_zero, 1'b0);

    step(v_zero, 1'b1);
    check("all_zero", v_zero, 1'b1);
    step(v_ones, 1'b1);
    check("all_ones", v_ones, 1'b1);

    // back-to-back wrap and row-isolation vectors, then idle
    step(v_wrap, 1'b1);
    check("wrap", e_wrap, 1'b1);
    step(v_row, 1'b1);
    check("row_iso", e_row, 1'b1);
    step(v_ones, 1'b0);
    check("hold_idle", e_row, 1'b0);
    step(v_zero, 1'b0);
    check("hold_idle2", e_row, 1'b0);

    // asynchronous reset between edges while a result is presented
    step(v_wrap, 1'b1);
    check("pre_reset", e_wrap, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("async_reset", v_zero, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    din = v_row;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    check("first_after_reset", e_row, 1'b1);

    for (int n = 0; n < 1000; n++) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        v_rand[i] = {$urandom, $urandom};
      end
      step(v_rand, 1'b1);
      check("random", chi_model(v_rand), 1'b1);
    end

    step(v_zero, 1'b0);
    check("final_idle", chi_model(v_rand), 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
